// File: rtl/fetch_inst_buffer.sv
// rtl/fetch_inst_buffer.sv - fetch instruction buffer: 4-wide block fill, 2-wide in-order drain to decode
// Optional perf counters enabled by defining FETCH_PERF_CNT_EN.
`ifndef ADDR_LEN
`define ADDR_LEN 32
`endif
`ifndef INSN_LEN
`define INSN_LEN 32
`endif

module fetch_inst_buffer #(
  parameter int                    DEPTH    = 8,
  parameter int                    IBUF_SEL = 3,
  parameter logic [`ADDR_LEN-1:0]  RESET_PC = '0
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  output logic [`ADDR_LEN-1:0]     pc_o,
  input  logic [4*`INSN_LEN-1:0]   idata_i,
  input  logic                     stall_dp_i,
  input  logic                     redirect_i,
  input  logic [`ADDR_LEN-1:0]     redirect_pc_i,
  output logic [`INSN_LEN-1:0]     inst_1_o,
  output logic [`INSN_LEN-1:0]     inst_2_o,
  output logic [`ADDR_LEN-1:0]     pc_1_o,
  output logic [`ADDR_LEN-1:0]     pc_2_o,
  output logic                     inst_valid_1_o,
  output logic                     inst_valid_2_o,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]              fetch_stall_cnt_o,
  output logic [31:0]              flush_cnt_o,
`endif
  output logic [IBUF_SEL:0]        ibuf_count_o
);

  localparam int CW = IBUF_SEL + 1;
  localparam logic [CW-1:0] ENQ_LIMIT = CW'(DEPTH - 4);

  logic [`INSN_LEN-1:0] insn_mem [DEPTH];
  logic [`ADDR_LEN-1:0] pc_mem   [DEPTH];
  logic [IBUF_SEL-1:0]  head, tail, head_nx;
  logic [CW-1:0]        count, count_nx;
  logic                 enq;
  logic [1:0]           deq;

  // Free space is judged on the start-of-cycle count; a same-cycle drain is not credited.
  assign enq     = !redirect_i && (count <= ENQ_LIMIT);
  assign head_nx = head + 1'b1;

  assign inst_valid_1_o = (count != '0);
  assign inst_valid_2_o = (count >= CW'(2));
  assign inst_1_o       = inst_valid_1_o ? insn_mem[head]    : '0;
  assign pc_1_o         = inst_valid_1_o ? pc_mem[head]      : '0;
  assign inst_2_o       = inst_valid_2_o ? insn_mem[head_nx] : '0;
  assign pc_2_o         = inst_valid_2_o ? pc_mem[head_nx]   : '0;
  assign ibuf_count_o   = count;

  assign deq      = stall_dp_i ? 2'd0 : ({1'b0, inst_valid_1_o} + {1'b0, inst_valid_2_o});
  assign count_nx = count + (enq ? CW'(4) : '0) - CW'(deq);

  always_ff @(posedge clk_i) begin
    if (enq) begin
      for (int k = 0; k < 4; k++) begin
        insn_mem[tail + IBUF_SEL'(k)] <= idata_i[k*`INSN_LEN +: `INSN_LEN];
        pc_mem[tail + IBUF_SEL'(k)]   <= pc_o + `ADDR_LEN'(4*k);
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pc_o  <= RESET_PC;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (redirect_i) begin
      pc_o  <= redirect_pc_i & ~`ADDR_LEN'(3);
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) begin
        tail <= tail + IBUF_SEL'(4);
        pc_o <= pc_o + `ADDR_LEN'(16);
      end
      head  <= head + IBUF_SEL'(deq);
      count <= count_nx;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // A redirect cycle counts as a flush only, never as a full-buffer stall.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      fetch_stall_cnt_o <= '0;
      flush_cnt_o       <= '0;
    end else if (redirect_i) begin
      flush_cnt_o <= flush_cnt_o + 32'd1;
    end else if (!enq) begin
      fetch_stall_cnt_o <= fetch_stall_cnt_o + 32'd1;
    end
  end
`endif

  a_count_even: assert property (@(posedge clk_i) disable iff (reset_i) count[0] == 1'b0);
  a_count_max:  assert property (@(posedge clk_i) disable iff (reset_i) count <= CW'(DEPTH));

endmodule
